tl_ul_memory_responder: RTL and testbench
=========================================

TL_UL_MEMORY_RESPONDER -- requirements
Module: tl_ul_memory_responder

Interface
REQ-001 The block SHALL have parameters BW_ADDR (default 32, address width), BW_DATA (default 32, data width, power of two >= 8), BW_SIZE (default 3, a_size/d_size width), BW_SOURCE (default 4, source ID width) and BW_SINK (default 1, sink ID width); BW_MASK SHALL equal BW_DATA/8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstp  input  1  reset, synchronous and active-high.
REQ-004 a_valid, a_ready  input/output  1 each  TileLink A-channel handshake.
REQ-005 a_opcode  input  3  a_param  input  3  a_size  input  BW_SIZE  a_source  input  BW_SOURCE  a_address  input  BW_ADDR  a_mask  input  BW_MASK  a_data  input  BW_DATA  A-channel payload.
REQ-006 d_valid, d_ready  output/input  1 each  TileLink D-channel handshake.
REQ-007 d_opcode  output  3  d_param  output  2  d_size  output  BW_SIZE  d_source  output  BW_SOURCE  d_sink  output  BW_SINK  d_denied  output  1  d_data  output  BW_DATA  d_corrupt  output  1  D-channel payload.
REQ-008 mreq_valid, mreq_ready  output/input  1 each  memory-side request handshake.
REQ-009 mreq_write  output  1  mreq_addr  output  BW_ADDR  mreq_wstrb  output  BW_MASK  mreq_wdata  output  BW_DATA  memory-side request payload.
REQ-010 mrsp_valid  input  1  mrsp_rdata  input  BW_DATA  mrsp_error  input  1  memory-side single-cycle response pulse; no back-pressure.

Function
REQ-011 Supported A opcodes SHALL be PutFullData (0), PutPartialData (1) and Get (4); a_param SHALL be ignored.
REQ-012 FSM states SHALL be IDLE, MREQ, MWAIT and DRESP; at most one transaction SHALL be in flight.
REQ-013 a_ready SHALL be 1 only in IDLE; an A beat is accepted when a_valid & a_ready, and opcode, size, source, address, mask and data SHALL be captured into registers on that edge.
REQ-014 On accept, a legal request (supported opcode and a_size <= log2(BW_MASK)) SHALL go IDLE->MREQ; an illegal one SHALL go IDLE->DRESP without any memory access.
REQ-015 In MREQ, mreq_valid SHALL be 1 with the captured payload held stable: mreq_write=1 for Puts, 0 for Get; mreq_wstrb=captured mask for Puts, all-ones for Get; mreq_wdata=captured data.
REQ-016 MREQ->MWAIT SHALL occur on mreq_valid & mreq_ready; mreq_valid SHALL be 0 in all other states.
REQ-017 In MWAIT, mrsp_valid SHALL capture mrsp_rdata (Get only) and mrsp_error, and move to DRESP; mrsp_valid in any other state SHALL be ignored.
REQ-018 An mrsp_valid in the same cycle as the mreq handshake SHALL be ignored; the response is counted only from MWAIT.
REQ-019 In DRESP, d_valid SHALL be 1 with payload held stable until d_ready; DRESP->IDLE SHALL occur on d_valid & d_ready.
REQ-020 d_opcode SHALL be AccessAckData (1) for Get, AccessAck (0) otherwise (including illegal opcodes); d_param=0, d_sink=0, d_size and d_source SHALL echo the captured values.
REQ-021 d_denied SHALL be 1 for an illegal request or a captured mrsp_error; d_corrupt SHALL be 1 when d_denied=1 and d_opcode=AccessAckData, else 0.
REQ-022 d_data SHALL be the captured rdata for a successful Get and 0 otherwise.
REQ-023 Minimum latency SHALL be: A accept at cycle N, mreq_valid at N+1, mrsp at N+2 earliest, d_valid at N+3; illegal requests SHALL show d_valid at N+1.
REQ-024 A new A beat SHALL not be accepted in the cycle the D handshake completes; a_ready rises the following cycle.

Reset
REQ-025 While rstp=1 at a clock edge, the FSM SHALL go to IDLE and all captured registers SHALL clear to 0, aborting any in-flight transaction without a D response.
REQ-026 Immediately after reset, a_ready=1, and d_valid, mreq_valid, d_denied, d_corrupt and d_data SHALL be 0.

Verification
REQ-027 Get addr 0x100, source 3, size 2; mem ready immediately, rdata 0xDEADBEEF one cycle later -> AccessAckData, source 3, size 2, data 0xDEADBEEF, denied 0, d_valid at accept+3.
REQ-028 PutPartialData mask 0x3, data 0x12345678, mreq_ready low 4 cycles -> mreq payload stable 5 cycles, wstrb 0x3, then AccessAck, denied 0.
REQ-029 Opcode 2 or a_size=3 with BW_DATA=32 -> no mreq_valid, d_valid next cycle, denied 1; corrupt 0 for the Put-class response.
REQ-030 Get with mrsp_error=1 -> AccessAckData, denied 1, corrupt 1, data 0; d_ready held low 3 cycles -> payload stable, a_ready 0 throughout.
REQ-031 rstp asserted in MWAIT -> next cycle IDLE, a_ready 1, no d_valid; a later mrsp_valid pulse SHALL be ignored.

Source files
------------

// File: rtl/tl_ul_memory_responder.sv
// rtl/tl_ul_memory_responder.sv - TileLink-UL slave that turns one A beat into one memory request and one D beat.
module tl_ul_memory_responder #(
  parameter int BW_ADDR   = 32,
  parameter int BW_DATA   = 32,
  parameter int BW_SIZE   = 3,
  parameter int BW_SOURCE = 4,
  parameter int BW_SINK   = 1,
  localparam int BW_MASK  = BW_DATA / 8
) (
  input  logic                 clk,
  input  logic                 rstp,

  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [2:0]           a_opcode,
  input  logic [2:0]           a_param,
  input  logic [BW_SIZE-1:0]   a_size,
  input  logic [BW_SOURCE-1:0] a_source,
  input  logic [BW_ADDR-1:0]   a_address,
  input  logic [BW_MASK-1:0]   a_mask,
  input  logic [BW_DATA-1:0]   a_data,

  output logic                 d_valid,
  input  logic                 d_ready,
  output logic [2:0]           d_opcode,
  output logic [1:0]           d_param,
  output logic [BW_SIZE-1:0]   d_size,
  output logic [BW_SOURCE-1:0] d_source,
  output logic [BW_SINK-1:0]   d_sink,
  output logic                 d_denied,
  output logic [BW_DATA-1:0]   d_data,
  output logic                 d_corrupt,

  output logic                 mreq_valid,
  input  logic                 mreq_ready,
  output logic                 mreq_write,
  output logic [BW_ADDR-1:0]   mreq_addr,
  output logic [BW_MASK-1:0]   mreq_wstrb,
  output logic [BW_DATA-1:0]   mreq_wdata,

  input  logic                 mrsp_valid,
  input  logic [BW_DATA-1:0]   mrsp_rdata,
  input  logic                 mrsp_error
);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;
  localparam int         LOG2_MASK      = $clog2(BW_MASK);
  localparam logic [BW_SIZE-1:0] MAX_SIZE = BW_SIZE'(LOG2_MASK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MREQ  = 2'd1,
    MWAIT = 2'd2,
    DRESP = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2:0]           op_q;
  logic [BW_SIZE-1:0]   size_q;
  logic [BW_SOURCE-1:0] source_q;
  logic [BW_ADDR-1:0]   addr_q;
  logic [BW_MASK-1:0]   mask_q;
  logic [BW_DATA-1:0]   data_q;
  logic [BW_DATA-1:0]   rdata_q;
  logic                 err_q;
  logic                 illegal_q;

  logic a_op_ok, a_legal, accept, rsp_take;
  logic is_get, denied, in_dresp;
  logic unused_param;

  assign unused_param = ^a_param;

  assign a_op_ok = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) ||
                   (a_opcode == OP_GET);
  assign a_legal = a_op_ok && (a_size <= MAX_SIZE);
  assign accept  = a_valid & a_ready;
  // Responses outside MWAIT (including the mreq handshake cycle) are dropped.
  assign rsp_take = (state == MWAIT) && mrsp_valid;

  always_ff @(posedge clk) begin
    if (rstp) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    mreq_valid = 1'b0;
    d_valid    = 1'b0;
    case (state)
      IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          state_next = a_legal ? MREQ : DRESP;
        end
      end
      MREQ: begin
        mreq_valid = 1'b1;
        if (mreq_ready) begin
          state_next = MWAIT;
        end
      end
      MWAIT: begin
        if (mrsp_valid) begin
          state_next = DRESP;
        end
      end
      DRESP: begin
        d_valid = 1'b1;
        if (d_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      op_q      <= '0;
      size_q    <= '0;
      source_q  <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= a_opcode;
        size_q    <= a_size;
        source_q  <= a_source;
        addr_q    <= a_address;
        mask_q    <= a_mask;
        data_q    <= a_data;
        rdata_q   <= '0;
        err_q     <= 1'b0;
        illegal_q <= ~a_legal;
      end
      if (rsp_take) begin
        err_q <= mrsp_error;
        if (op_q == OP_GET) begin
          rdata_q <= mrsp_rdata;
        end
      end
    end
  end

  assign is_get   = (op_q == OP_GET);
  assign denied   = illegal_q | err_q;
  assign in_dresp = (state == DRESP);

  assign mreq_write = ~is_get;
  assign mreq_addr  = addr_q;
  assign mreq_wstrb = is_get ? {BW_MASK{1'b1}} : mask_q;
  assign mreq_wdata = data_q;

  assign d_opcode  = is_get ? D_ACK_DATA : D_ACK;
  assign d_param   = '0;
  assign d_size    = size_q;
  assign d_source  = source_q;
  assign d_sink    = '0;
  assign d_denied  = in_dresp & denied;
  assign d_corrupt = in_dresp & denied & is_get;
  assign d_data    = (in_dresp && is_get && !denied) ? rdata_q : '0;

endmodule

// File: tb/tb_tl_ul_memory_responder.sv
// tb/tb_tl_ul_memory_responder.sv - directed bench with a transaction-level response model.
module tb_tl_ul_memory_responder;

  logic        clk;
  logic        rstp;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [0:0]  d_sink;
  logic        d_denied, d_corrupt;
  logic [31:0] d_data;
  logic        mreq_valid, mreq_ready, mreq_write;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mrsp_valid, mrsp_error;
  logic [31:0] mrsp_rdata;

  tl_ul_memory_responder dut (
    .clk(clk), .rstp(rstp),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_write(mreq_write),
    .mreq_addr(mreq_addr), .mreq_wstrb(mreq_wstrb), .mreq_wdata(mreq_wdata),
    .mrsp_valid(mrsp_valid), .mrsp_rdata(mrsp_rdata), .mrsp_error(mrsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } d_exp_t;

  int errors = 0;
  int checks = 0;

  bit          chk_en;
  bit          exp_mreq_on, exp_wait_on, exp_d_on;
  logic        exp_mreq_write;
  logic [31:0] exp_mreq_addr, exp_mreq_wdata;
  logic [3:0]  exp_mreq_wstrb;
  d_exp_t      exp_d;

  int          cyc, d_lat, d_cnt, mreq_cnt;
  logic [2:0]  last_op;
  logic [3:0]  last_src;
  logic        last_denied, last_corrupt;
  logic [31:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected D beat derived directly from the opcode/size legality rules.
  function automatic d_exp_t predict(input logic [2:0] op, input logic [2:0] size,
                                     input logic [3:0] src, input logic [31:0] rdata,
                                     input logic err);
    d_exp_t e;
    logic   legal, get;
    get       = (op == 3'd4);
    legal     = (op == 3'd0 || op == 3'd1 || get) && (size <= 3'd2);
    e.op      = get ? 3'd1 : 3'd0;
    e.size    = size;
    e.src     = src;
    e.denied  = !legal || err;
    e.corrupt = e.denied && get;
    e.data    = (get && !e.denied) ? rdata : 32'h0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ready", a_ready, !(exp_mreq_on || exp_wait_on || exp_d_on));
      chk("mreq_valid", mreq_valid, exp_mreq_on);
      chk("d_valid", d_valid, exp_d_on);
      if (mreq_valid && exp_mreq_on) begin
        chk("mreq_write", mreq_write, exp_mreq_write);
        chk("mreq_addr", mreq_addr, exp_mreq_addr);
        chk("mreq_wstrb", mreq_wstrb, exp_mreq_wstrb);
        chk("mreq_wdata", mreq_wdata, exp_mreq_wdata);
      end
      if (d_valid && exp_d_on) begin
        chk("d_opcode", d_opcode, exp_d.op);
        chk("d_param", d_param, 2'd0);
        chk("d_size", d_size, exp_d.size);
        chk("d_source", d_source, exp_d.src);
        chk("d_sink", d_sink, 1'b0);
        chk("d_denied", d_denied, exp_d.denied);
        chk("d_corrupt", d_corrupt, exp_d.corrupt);
        chk("d_data", d_data, exp_d.data);
      end
    end
  end

  task automatic run_txn(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wdata,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                         input logic err, input int dr_dly, input bit stray, input bit abort);
    bit legal, hs;
    int n;
    legal = (op == 3'd0 || op == 3'd1 || op == 3'd4) && (size <= 3'd2);
    a_valid = 1'b1; a_opcode = op; a_param = 3'd5; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = wdata;
    hs = 0; n = 0;
    while (!hs && n < 10) begin
      @(negedge clk);
      hs = a_ready;
      if (!hs) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("a_accept", hs, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0; a_opcode = 3'd7; a_size = 3'd7; a_source = 4'hF;
    a_address = 32'hFFFF_FFFF; a_mask = 4'hA; a_data = 32'hA5A5_A5A5;
    cyc = 1; d_lat = 0; d_cnt = 0; mreq_cnt = 0;
    exp_d = predict(op, size, src, rdata, legal ? err : 1'b0);
    if (legal) begin
      exp_mreq_write = (op != 3'd4);
      exp_mreq_addr  = addr;
      exp_mreq_wstrb = (op == 3'd4) ? 4'hF : mask;
      exp_mreq_wdata = wdata;
      exp_mreq_on    = 1'b1;
      mreq_ready = (rdy_dly == 0);
      hs = 0; n = 0;
      while (!hs && n < 50) begin
        if (stray && mreq_ready) begin
          mrsp_valid = 1'b1; mrsp_rdata = 32'hBAD0_BAD0; mrsp_error = 1'b1;
        end
        @(negedge clk);
        if (mreq_valid) mreq_cnt++;
        hs = mreq_valid && mreq_ready;
        @(posedge clk); #1;
        cyc++; n++;
        mrsp_valid = 1'b0; mrsp_error = 1'b0;
        if (mreq_cnt >= rdy_dly) mreq_ready = 1'b1;
      end
      mreq_ready = 1'b0;
      exp_mreq_on = 1'b0;
      chk("mreq_handshake", hs, 1'b1);
      exp_wait_on = 1'b1;
      if (abort) begin
        rstp = 1'b1;
        @(posedge clk); #1;
        rstp = 1'b0;
        exp_wait_on = 1'b0;
        return;
      end
      repeat (rsp_dly) begin
        @(posedge clk); #1;
        cyc++;
      end
      mrsp_valid = 1'b1; mrsp_rdata = rdata; mrsp_error = err;
      @(posedge clk); #1;
      cyc++;
      mrsp_valid = 1'b0; mrsp_rdata = 32'h5A5A_5A5A; mrsp_error = 1'b1;
      exp_wait_on = 1'b0;
    end
    exp_d_on = 1'b1;
    d_ready = (dr_dly == 0);
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      if (d_valid) begin
        if (d_cnt == 0) d_lat = cyc;
        d_cnt++;
        last_op = d_opcode; last_src = d_source; last_denied = d_denied;
        last_corrupt = d_corrupt; last_data = d_data;
      end
      hs = d_valid && d_ready;
      @(posedge clk); #1;
      cyc++; n++;
      if (d_cnt >= dr_dly) d_ready = 1'b1;
    end
    d_ready = 1'b0;
    exp_d_on = 1'b0;
    mrsp_error = 1'b0;
    chk("d_handshake", hs, 1'b1);
  endtask

  initial begin
    rstp = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0;
    mreq_ready = 1'b0; mrsp_valid = 1'b0; mrsp_rdata = '0; mrsp_error = 1'b0;
    chk_en = 0;
    repeat (3) @(posedge clk);
    #1 rstp = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_mreq_valid", mreq_valid, 1'b0);
    chk("rst_d_denied", d_denied, 1'b0);
    chk("rst_d_corrupt", d_corrupt, 1'b0);
    chk("rst_d_data", d_data, 32'h0);
    @(posedge clk); #1;

    // Get, immediate memory response
    run_txn(3'd4, 3'd2, 4'd3, 32'h100, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    chk("t1_latency", d_lat, 3);
    chk("t1_opcode", last_op, 3'd1);
    chk("t1_source", last_src, 4'd3);
    chk("t1_data", last_data, 32'hDEAD_BEEF);
    chk("t1_denied", last_denied, 1'b0);

    // PutPartialData with memory back-pressure; read data must not leak
    run_txn(3'd1, 3'd2, 4'd5, 32'h204, 4'h3, 32'h1234_5678, 4, 0, 32'h1111_2222, 1'b0, 0, 0, 0);
    chk("t2_mreq_cycles", mreq_cnt, 5);
    chk("t2_latency", d_lat, 7);
    chk("t2_opcode", last_op, 3'd0);
    chk("t2_denied", last_denied, 1'b0);
    chk("t2_data", last_data, 32'h0);

    // Unsupported opcode 2
    run_txn(3'd2, 3'd2, 4'd1, 32'h40, 4'hF, 32'hFEED_0001, 0, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("t3_latency", d_lat, 1);
    chk("t3_denied", last_denied, 1'b1);
    chk("t3_corrupt", last_corrupt, 1'b0);
    chk("t3_opcode", last_op, 3'd0);

    // Oversized PutFullData and Get
    run_txn(3'd0, 3'd3, 4'd2, 32'h80, 4'hF, 32'hFEED_0002, 0, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("t4_latency", d_lat, 1);
    chk("t4_denied", last_denied, 1'b1);
    chk("t4_corrupt", last_corrupt, 1'b0);
    run_txn(3'd4, 3'd3, 4'd6, 32'h88, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("t5_latency", d_lat, 1);
    chk("t5_corrupt", last_corrupt, 1'b1);
    chk("t5_opcode", last_op, 3'd1);

    // Get with memory error and D back-pressure
    run_txn(3'd4, 3'd2, 4'd7, 32'h1F0, 4'hF, 32'h0, 1, 1, 32'h7777_8888, 1'b1, 3, 0, 0);
    chk("t6_d_cycles", d_cnt, 4);
    chk("t6_denied", last_denied, 1'b1);
    chk("t6_corrupt", last_corrupt, 1'b1);
    chk("t6_data", last_data, 32'h0);

    // Stray response during the mreq handshake is ignored
    run_txn(3'd4, 3'd1, 4'd9, 32'h300, 4'hF, 32'h0, 0, 2, 32'hCAFE_F00D, 1'b0, 0, 1, 0);
    chk("t7_latency", d_lat, 5);
    chk("t7_data", last_data, 32'hCAFE_F00D);
    chk("t7_denied", last_denied, 1'b0);

    // Reset while waiting on memory, then a late response
    run_txn(3'd4, 3'd2, 4'd4, 32'h400, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 0, 0, 1);
    @(negedge clk);
    chk("t8_a_ready", a_ready, 1'b1);
    chk("t8_d_valid", d_valid, 1'b0);
    @(posedge clk); #1;
    mrsp_valid = 1'b1; mrsp_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    mrsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // PutFullData after the abort
    run_txn(3'd0, 3'd0, 4'd8, 32'h500, 4'hF, 32'h0BAD_CAFE, 0, 0, 32'h0, 1'b0, 0, 0, 0);
    chk("t9_latency", d_lat, 3);
    chk("t9_denied", last_denied, 1'b0);
    chk("t9_source", last_src, 4'd8);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
